// File: rtl/imem_fetch_ctrl_if.sv
// -----------------------------------------------------------------------------
// imem_fetch_ctrl_if
// Bundles the instruction-memory port, the redirect inputs and the
// valid/ready hand-off to decode for imem_fetch_ctrl.
//   master : the fetch controller side
//   slave  : the environment side (memory, decode, branch unit)
// -----------------------------------------------------------------------------
interface imem_fetch_ctrl_if #(
    parameter int FIFO_DEPTH = 4
) ();
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic          fetch_en;
    logic          redirect_valid;
    logic [31:0]   redirect_pc;
    logic [31:0]   imem_addr;
    logic [31:0]   imem_rdata;
    logic          fetch_valid;
    logic [31:0]   fetch_instr;
    logic [31:0]   fetch_pc;
    logic          fetch_ready;
    logic [CW-1:0] fifo_count;
    logic          halted;
    logic          misalign_err;

    modport master (
        input  fetch_en,
        input  redirect_valid,
        input  redirect_pc,
        input  imem_rdata,
        input  fetch_ready,
        output imem_addr,
        output fetch_valid,
        output fetch_instr,
        output fetch_pc,
        output fifo_count,
        output halted,
        output misalign_err
    );

    modport slave (
        output fetch_en,
        output redirect_valid,
        output redirect_pc,
        output imem_rdata,
        output fetch_ready,
        input  imem_addr,
        input  fetch_valid,
        input  fetch_instr,
        input  fetch_pc,
        input  fifo_count,
        input  halted,
        input  misalign_err
    );
endinterface

// File: rtl/imem_fetch_ctrl.sv
// -----------------------------------------------------------------------------
// imem_fetch_ctrl
// Instruction-fetch sequencer: owns the PC, presents it to the instruction
// memory, captures {pc, word} into a small prefetch FIFO and hands the head
// to decode over valid/ready. Redirects flush the FIFO and reload the PC; a
// fetched HALT_INSTR stops further fetching until the next redirect.
//
// Optional feature macro: FETCH_MISALIGN_CHK_EN
//   defined   : a redirect whose target has bits [1:0] != 0 flushes, keeps the
//               PC, enters HALT and sets the sticky misalign_err flag.
//   undefined : misalign_err is 0 and target bits [1:0] are simply cleared.
// -----------------------------------------------------------------------------
module imem_fetch_ctrl #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          IMEM_BYTES = 32,
    parameter int          FIFO_DEPTH = 4,
    parameter logic [31:0] HALT_INSTR = 32'h0000_0073
) (
    input  logic               clk,
    input  logic               reset_n,
    imem_fetch_ctrl_if.master  bus
);

    localparam int             AW      = $clog2(FIFO_DEPTH);
    localparam int             CW      = AW + 1;
    // Address mask: wraps modulo IMEM_BYTES and forces word alignment.
    localparam logic [31:0]    PC_MASK = (32'(IMEM_BYTES) - 32'd1) & ~32'h0000_0003;
    localparam logic [CW-1:0]  DEPTH_C = CW'(FIFO_DEPTH);
    localparam logic [CW-1:0]  CNT_ONE = CW'(1);
    localparam logic [CW-1:0]  CNT_ZERO = CW'(0);
    localparam logic [AW-1:0]  PTR_ONE = AW'(1);
    localparam logic [AW-1:0]  PTR_ZERO = AW'(0);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_HALT  = 2'd2
    } state_t;

    // Wrap an address into the instruction memory and align it to a word.
    function automatic logic [31:0] wrap_pc(input logic [31:0] addr);
        return addr & PC_MASK;
    endfunction

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_t         r_state;
    logic [31:0]    r_pc;
    logic [CW-1:0]  r_count;
    logic [AW-1:0]  r_wr_ptr;
    logic [AW-1:0]  r_rd_ptr;
    logic [31:0]    r_buf_pc    [FIFO_DEPTH];
    logic [31:0]    r_buf_instr [FIFO_DEPTH];
`ifdef FETCH_MISALIGN_CHK_EN
    logic           r_misalign;
`endif

    // ------------------------------------------------------------------
    // Control decode
    // ------------------------------------------------------------------
    logic           w_redirect;
    logic           w_misalign;
    logic           w_fifo_nonempty;
    logic           w_pop;
    logic           w_push_ok;
    logic           w_push;
    logic           w_is_halt;
    logic [31:0]    w_pc_inc;
    logic [31:0]    w_redir_pc;

    // Derive push/pop qualifiers; a redirect blocks both in its cycle.
    always_comb begin
        w_redirect      = bus.redirect_valid;
        w_misalign      = 1'b0;
        w_fifo_nonempty = (r_count != CNT_ZERO);
        w_pop           = 1'b0;
        w_push_ok       = 1'b0;
        w_push          = 1'b0;
        w_is_halt       = (bus.imem_rdata == HALT_INSTR);
        w_pc_inc        = wrap_pc(r_pc + 32'd4);
        w_redir_pc      = wrap_pc(bus.redirect_pc);

`ifdef FETCH_MISALIGN_CHK_EN
        if (w_redirect && (bus.redirect_pc[1:0] != 2'b00)) begin
            w_misalign = 1'b1;
        end else begin
            w_misalign = 1'b0;
        end
`endif

        if (w_redirect) begin
            w_pop     = 1'b0;
            w_push_ok = 1'b0;
        end else begin
            w_pop     = w_fifo_nonempty & bus.fetch_ready;
            // A full FIFO still accepts a push when the head leaves this cycle.
            w_push_ok = bus.fetch_en & ((r_count < DEPTH_C) | w_pop);
        end

        if (r_state == ST_FETCH) begin
            w_push = w_push_ok;
        end else begin
            w_push = 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Sequencer FSM and PC register
    // ------------------------------------------------------------------
    // Track fetch state, advance the PC on each push, apply redirects.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
            r_pc    <= RESET_PC;
`ifdef FETCH_MISALIGN_CHK_EN
            r_misalign <= 1'b0;
`endif
        end else if (w_redirect) begin
            if (w_misalign) begin
                // Misaligned target: keep the PC, stop fetching, flag it.
                r_state <= ST_HALT;
`ifdef FETCH_MISALIGN_CHK_EN
                r_misalign <= 1'b1;
`endif
            end else begin
                r_pc <= w_redir_pc;
                case (r_state)
                    ST_IDLE:  r_state <= ST_IDLE;
                    ST_FETCH: r_state <= bus.fetch_en ? ST_FETCH : ST_IDLE;
                    ST_HALT:  r_state <= ST_FETCH;
                    default:  r_state <= ST_IDLE;
                endcase
            end
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (bus.fetch_en) begin
                        r_state <= ST_FETCH;
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_FETCH: begin
                    if (!bus.fetch_en) begin
                        r_state <= ST_IDLE;
                    end else if (w_push) begin
                        r_pc <= w_pc_inc;
                        // The halt word itself is delivered; only later fetches stop.
                        if (w_is_halt) begin
                            r_state <= ST_HALT;
                        end else begin
                            r_state <= ST_FETCH;
                        end
                    end else begin
                        r_state <= ST_FETCH;
                    end
                end
                ST_HALT: begin
                    r_state <= ST_HALT;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Prefetch FIFO
    // ------------------------------------------------------------------
    // Store {pc, word} on push, retire the head on pop, drop all on redirect.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_count  <= CNT_ZERO;
            r_wr_ptr <= PTR_ZERO;
            r_rd_ptr <= PTR_ZERO;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                r_buf_pc[i]    <= 32'h0000_0000;
                r_buf_instr[i] <= 32'h0000_0000;
            end
        end else if (w_redirect) begin
            r_count  <= CNT_ZERO;
            r_wr_ptr <= PTR_ZERO;
            r_rd_ptr <= PTR_ZERO;
        end else begin
            if (w_push) begin
                r_buf_pc[r_wr_ptr]    <= r_pc;
                r_buf_instr[r_wr_ptr] <= bus.imem_rdata;
                r_wr_ptr              <= r_wr_ptr + PTR_ONE;
            end else begin
                r_wr_ptr <= r_wr_ptr;
            end

            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_ONE;
            end else begin
                r_rd_ptr <= r_rd_ptr;
            end

            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_ONE;
                2'b01:   r_count <= r_count - CNT_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Outputs (all decoded directly from registers)
    // ------------------------------------------------------------------
    assign bus.imem_addr   = r_pc;
    assign bus.fifo_count  = r_count;
    assign bus.fetch_valid = w_fifo_nonempty;
    // Head fields read as zero while the FIFO is empty so flushed data never shows.
    assign bus.fetch_instr = w_fifo_nonempty ? r_buf_instr[r_rd_ptr] : 32'h0000_0000;
    assign bus.fetch_pc    = w_fifo_nonempty ? r_buf_pc[r_rd_ptr]    : 32'h0000_0000;
    assign bus.halted      = (r_state == ST_HALT);
`ifdef FETCH_MISALIGN_CHK_EN
    assign bus.misalign_err = r_misalign;
`else
    assign bus.misalign_err = 1'b0;
`endif

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// -----------------------------------------------------------------------------
// tb_imem_fetch_ctrl
// Self-checking bench for imem_fetch_ctrl (IMEM_BYTES = 32, FIFO_DEPTH = 4).
// Each scenario queues the {pc, instr} pairs decode should receive; a monitor
// pops and compares on every accepted hand-off. Scenario-level checks cover
// reset, back-pressure, wrap, flush, halt and the misaligned-redirect option.
// -----------------------------------------------------------------------------
module tb_imem_fetch_ctrl;

    logic clk     = 1'b0;
    logic reset_n = 1'b0;

    logic [31:0] r_mem [8];
    logic [63:0] exp_q [$];
    int          n_checks = 0;
    int          n_pass   = 0;

    imem_fetch_ctrl_if #(.FIFO_DEPTH(4)) u_bus ();

    imem_fetch_ctrl #(
        .RESET_PC   (32'h0000_0000),
        .IMEM_BYTES (32),
        .FIFO_DEPTH (4),
        .HALT_INSTR (32'h0000_0073)
    ) u_dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (u_bus)
    );

    // Combinational instruction memory model.
    assign u_bus.imem_rdata = r_mem[u_bus.imem_addr[4:2]];

    // 10 ns clock.
    always #5 clk = ~clk;

    // Compare one observed value against its expectation and keep score.
    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    // Queue the hand-off expected for a given PC using the current memory image.
    task automatic push_exp(input logic [31:0] pc);
        exp_q.push_back({pc, r_mem[pc[4:2]]});
    endtask

    // Advance n clock edges, leaving time just after the last edge.
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // One-cycle redirect pulse.
    task automatic redirect(input logic [31:0] tgt);
        u_bus.redirect_valid = 1'b1;
        u_bus.redirect_pc    = tgt;
        tick(1);
        u_bus.redirect_valid = 1'b0;
    endtask

    // Scoreboard: every accepted hand-off must match the oldest expectation.
    always @(negedge clk) begin
        if (reset_n && u_bus.fetch_valid && u_bus.fetch_ready && !u_bus.redirect_valid) begin
            if (exp_q.size() == 0) begin
                check_eq("unexpected_delivery_pc", u_bus.fetch_pc, 32'hFFFF_FFFF);
            end else begin
                logic [63:0] e;
                e = exp_q.pop_front();
                check_eq("deliver_pc",    u_bus.fetch_pc,    e[63:32]);
                check_eq("deliver_instr", u_bus.fetch_instr, e[31:0]);
            end
        end
    end

    initial begin
        for (int i = 0; i < 8; i++) begin
            r_mem[i] = 32'h0000_0013 | (32'(i) << 15);
        end
        r_mem[0] = 32'h0050_0093;
        r_mem[1] = 32'h0010_8113;

        u_bus.fetch_en       = 1'b1;
        u_bus.fetch_ready    = 1'b1;
        u_bus.redirect_valid = 1'b0;
        u_bus.redirect_pc    = 32'h0000_0000;

        // ---------------- reset state ----------------
        tick(3);
        check_eq("rst_valid",    32'(u_bus.fetch_valid),  32'd0);
        check_eq("rst_count",    32'(u_bus.fifo_count),   32'd0);
        check_eq("rst_halted",   32'(u_bus.halted),       32'd0);
        check_eq("rst_misalign", 32'(u_bus.misalign_err), 32'd0);
        check_eq("rst_addr",     u_bus.imem_addr,         32'h0000_0000);
        check_eq("rst_pc",       u_bus.fetch_pc,          32'h0000_0000);
        check_eq("rst_instr",    u_bus.fetch_instr,       32'h0000_0000);

        // ---------------- A: first fetch latency and linear wrap ----------------
        for (int i = 0; i < 8; i++) push_exp(32'(i * 4));
        push_exp(32'h0);
        push_exp(32'h4);
        reset_n = 1'b1;
        tick(2);
        check_eq("first_valid", 32'(u_bus.fetch_valid), 32'd1);
        check_eq("first_pc",    u_bus.fetch_pc,         32'h0000_0000);
        check_eq("first_instr", u_bus.fetch_instr,      32'h0050_0093);
        tick(9);
        u_bus.fetch_en = 1'b0;
        tick(3);
        check_eq("a_count_drained", 32'(u_bus.fifo_count), 32'd0);
        check_eq("a_addr_after",    u_bus.imem_addr,       32'h0000_0008);

        // ---------------- B: back-pressure saturation ----------------
        redirect(32'h0000_0000);
        u_bus.fetch_ready = 1'b0;
        u_bus.fetch_en    = 1'b1;
        for (int i = 0; i < 8; i++) push_exp(32'(i * 4));
        push_exp(32'h0);
        tick(10);
        check_eq("bp_count", 32'(u_bus.fifo_count), 32'd4);
        check_eq("bp_head",  u_bus.fetch_pc,        32'h0000_0000);
        check_eq("bp_addr",  u_bus.imem_addr,       32'h0000_0010);
        u_bus.fetch_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick(1);
            check_eq("bp_no_gap", 32'(u_bus.fetch_valid), 32'd1);
        end
        u_bus.fetch_en = 1'b0;
        tick(6);
        check_eq("b_count_drained", 32'(u_bus.fifo_count), 32'd0);

        // ---------------- C: redirect flush with 3 entries ----------------
        u_bus.fetch_ready = 1'b0;
        u_bus.fetch_en    = 1'b1;
        push_exp(32'h10);
        push_exp(32'h14);
        push_exp(32'h18);
        tick(4);
        check_eq("c_count_before", 32'(u_bus.fifo_count), 32'd3);
        redirect(32'h0000_0010);
        check_eq("c_count_flushed", 32'(u_bus.fifo_count),  32'd0);
        check_eq("c_valid_flushed", 32'(u_bus.fetch_valid), 32'd0);
        check_eq("c_addr_redir",    u_bus.imem_addr,        32'h0000_0010);
        u_bus.fetch_ready = 1'b1;
        tick(3);
        u_bus.fetch_en = 1'b0;
        tick(4);
        check_eq("c_count_drained", 32'(u_bus.fifo_count), 32'd0);

        // ---------------- D: halt instruction ----------------
        r_mem[2] = 32'h0000_0073;
        redirect(32'h0000_0000);
        u_bus.fetch_en = 1'b1;
        push_exp(32'h0);
        push_exp(32'h4);
        push_exp(32'h8);
        tick(4);
        check_eq("d_halted",      32'(u_bus.halted),      32'd1);
        check_eq("d_addr_halt",   u_bus.imem_addr,        32'h0000_000C);
        tick(4);
        check_eq("d_halt_hold",   32'(u_bus.halted),      32'd1);
        check_eq("d_no_push",     32'(u_bus.fifo_count),  32'd0);
        check_eq("d_addr_frozen", u_bus.imem_addr,        32'h0000_000C);
        push_exp(32'h0);
        push_exp(32'h4);
        push_exp(32'h8);
        redirect(32'h0000_0000);
        check_eq("d_resume_halted", 32'(u_bus.halted),    32'd0);
        check_eq("d_resume_addr",   u_bus.imem_addr,      32'h0000_0000);
        tick(6);
        check_eq("d_rehalted",      32'(u_bus.halted),    32'd1);

        // ---------------- E: misaligned redirect ----------------
`ifndef FETCH_MISALIGN_CHK_EN
        push_exp(32'h4);
        push_exp(32'h8);
`endif
        redirect(32'h0000_0006);
`ifdef FETCH_MISALIGN_CHK_EN
        check_eq("e_misalign", 32'(u_bus.misalign_err), 32'd1);
        check_eq("e_halted",   32'(u_bus.halted),       32'd1);
        check_eq("e_count",    32'(u_bus.fifo_count),   32'd0);
        check_eq("e_addr",     u_bus.imem_addr,         32'h0000_000C);
`else
        check_eq("e_misalign", 32'(u_bus.misalign_err), 32'd0);
        check_eq("e_halted",   32'(u_bus.halted),       32'd0);
        check_eq("e_addr",     u_bus.imem_addr,         32'h0000_0004);
`endif
        tick(6);
        check_eq("e_halted_later", 32'(u_bus.halted), 32'd1);
        push_exp(32'h0);
        push_exp(32'h4);
        push_exp(32'h8);
        redirect(32'h0000_0000);
        tick(6);
`ifdef FETCH_MISALIGN_CHK_EN
        check_eq("e_misalign_sticky", 32'(u_bus.misalign_err), 32'd1);
`else
        check_eq("e_misalign_zero",   32'(u_bus.misalign_err), 32'd0);
`endif

        // ---------------- F: reset mid-operation ----------------
        u_bus.fetch_ready = 1'b0;
        redirect(32'h0000_0000);
        tick(4);
        check_eq("f_count_before", 32'(u_bus.fifo_count), 32'd3);
        reset_n = 1'b0;
        #1;
        check_eq("f_count_reset",    32'(u_bus.fifo_count),   32'd0);
        check_eq("f_valid_reset",    32'(u_bus.fetch_valid),  32'd0);
        check_eq("f_halted_reset",   32'(u_bus.halted),       32'd0);
        check_eq("f_misalign_reset", 32'(u_bus.misalign_err), 32'd0);
        check_eq("f_addr_reset",     u_bus.imem_addr,         32'h0000_0000);

        check_eq("exp_left", 32'(exp_q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
